// File: rtl/testharness_pkg.sv
// Test-harness memory map constants shared by the on-chip memories.
package testharness_pkg;

  localparam logic [31:0] SLOW_MEMORY_START_ADDRESS = 32'h0002_0000;
  localparam logic [31:0] SLOW_MEMORY_SIZE          = 32'h0000_0200;

endpackage

// File: rtl/slow_obi_mem.sv
// Single-port OBI memory with a fixed, configurable response latency.
// One transaction in flight at a time: a grant is withheld while the
// previous response is still counting down, and re-opened in the
// response cycle so requests can stream back-to-back.
module slow_obi_mem
  import testharness_pkg::*;
#(
  parameter int unsigned NUM_WORDS = SLOW_MEMORY_SIZE / 4,
  parameter int unsigned LATENCY   = 4,
  parameter logic [31:0] BASE_ADDR = SLOW_MEMORY_START_ADDRESS
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  localparam logic [31:0]  ERR_PATTERN = 32'hBADCAB1E;
  localparam int unsigned  IDX_W       = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [3:0]   CNT_LOAD    = 4'(LATENCY - 1);

  // The 4-bit counter cannot represent longer latencies, and zero would
  // mean a same-cycle response that the FSM has no state for.
  if (LATENCY < 1 || LATENCY > 15) begin : g_latency_check
    $error("slow_obi_mem: LATENCY must be in 1..15");
  end

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [31:0]       rdata_q;
  logic [31:0]       mem_q [NUM_WORDS];
  logic [31:0]       offset;
  logic              in_range;
  logic [IDX_W-1:0]  idx;
  logic              unused_addr_lsb;

  // Word decode relative to the base; byte-offset bits are don't-care.
  assign offset          = addr_i - BASE_ADDR;
  assign in_range        = (addr_i >= BASE_ADDR) &&
                           ({2'b00, offset[31:2]} < 32'(NUM_WORDS));
  assign idx             = offset[IDX_W+1:2];
  assign unused_addr_lsb = ^offset[1:0];

  // Next-state, counter and handshake outputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gnt_o    = 1'b0;
    rvalid_o = 1'b0;
    case (state_q)
      IDLE: gnt_o = req_i;
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_d == 4'd0) state_d = RESP;
      end
      RESP: begin
        gnt_o    = req_i;
        rvalid_o = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A grant (only possible in IDLE or RESP) starts a new countdown.
    if (gnt_o) begin
      cnt_d   = CNT_LOAD;
      state_d = (LATENCY == 1) ? RESP : WAIT;
    end
  end

  // State, counter and captured response; reset drops any pending response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (gnt_o) begin
        if (we_i)          rdata_q <= 32'h0;
        else if (in_range) rdata_q <= mem_q[idx];
        else               rdata_q <= ERR_PATTERN;
      end
    end
  end

  // Byte-masked write commit at the grant edge; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (gnt_o && we_i && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[idx][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  // Data bus is quiet outside the response cycle.
  assign rdata_o = rvalid_o ? rdata_q : 32'h0;

endmodule

// File: tb/tb_slow_obi_mem.sv
// Scoreboard bench for slow_obi_mem: one instance at LATENCY=4, one at
// LATENCY=1. Drivers push expected responses (data + due cycle) computed
// from a word-array model; a negedge monitor pops and compares.
module tb_slow_obi_mem;
  import testharness_pkg::*;

  localparam logic [31:0] BASE   = SLOW_MEMORY_START_ADDRESS;
  localparam int          NWORDS = 128;
  localparam int          LAT0   = 4;
  localparam int          LAT1   = 1;

  typedef struct {
    int          inst;
    int          due;
    logic [31:0] data;
  } exp_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        req    [2];
  logic        gnt    [2];
  logic [31:0] addr   [2];
  logic        we     [2];
  logic [3:0]  be     [2];
  logic [31:0] wdata  [2];
  logic        rvalid [2];
  logic [31:0] rdata  [2];

  int          cyc    = 0;
  int          n_chk  = 0;
  int          n_pass = 0;
  exp_t        exp_q [$];
  logic [31:0] mm [2][NWORDS];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  slow_obi_mem #(.NUM_WORDS(NWORDS), .LATENCY(LAT0), .BASE_ADDR(BASE)) u_lat4 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[0]), .gnt_o(gnt[0]), .addr_i(addr[0]),
    .we_i(we[0]), .be_i(be[0]), .wdata_i(wdata[0]), .rvalid_o(rvalid[0]), .rdata_o(rdata[0])
  );

  slow_obi_mem #(.NUM_WORDS(NWORDS), .LATENCY(LAT1), .BASE_ADDR(BASE)) u_lat1 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[1]), .gnt_o(gnt[1]), .addr_i(addr[1]),
    .we_i(we[1]), .be_i(be[1]), .wdata_i(wdata[1]), .rvalid_o(rvalid[1]), .rdata_o(rdata[1])
  );

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int lat_of(input int i);
    return (i == 0) ? LAT0 : LAT1;
  endfunction

  // Reference behaviour: word-addressed array, byte-enable merge on writes,
  // error pattern outside the window, zero data on write responses.
  task automatic model_access(input int i, input bit w, input logic [31:0] a,
                              input logic [3:0] b, input logic [31:0] d, output logic [31:0] exp);
    logic [31:0] off;
    int          idx;
    off = a - BASE;
    idx = int'(off >> 2);
    if (a < BASE || (off >> 2) >= NWORDS) begin
      exp = w ? 32'h0 : 32'hBADCAB1E;
    end else if (w) begin
      for (int k = 0; k < 4; k++)
        if (b[k]) mm[i][idx][8*k +: 8] = d[8*k +: 8];
      exp = 32'h0;
    end else begin
      exp = mm[i][idx];
    end
  endtask

  // Called just after a posedge; returns just after the edge that ends the
  // grant cycle, with req still high so the caller may stream another.
  task automatic issue(input int i, input bit w, input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] d, output int g);
    bit          got;
    logic [31:0] e;
    exp_t        ent;
    got = 1'b0;
    g   = -1;
    req[i] = 1'b1; we[i] = w; addr[i] = a; be[i] = b; wdata[i] = d;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (gnt[i]) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!got) begin
      check(1'b0, "grant_timeout", a, 32'h0);
      req[i] = 1'b0;
    end else begin
      g = cyc;
      model_access(i, w, a, b, d, e);
      ent.inst = i; ent.due = g + lat_of(i); ent.data = e;
      exp_q.push_back(ent);
      @(posedge clk); #1;
    end
  endtask

  task automatic idle(input int i, input int n);
    req[i] = 1'b0;
    we[i]  = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [31:0] pick_addr();
    int          r;
    logic [31:0] low;
    r   = $urandom_range(0, 9);
    low = 32'($urandom_range(0, 3));
    if (r == 0)      return BASE - 32'(4 * $urandom_range(1, 8)) + low;
    else if (r == 1) return BASE + 32'h200 + 32'(4 * $urandom_range(0, 8)) + low;
    else             return BASE + 32'(4 * $urandom_range(0, NWORDS - 1)) + low;
  endfunction

  // Monitor: every response must be expected, on time and carry the right data.
  always @(negedge clk) begin : mon
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      if (rvalid[i] === 1'b1) begin
        if (exp_q.size() == 0 || exp_q[0].inst != i) begin
          check(1'b0, "unexpected_rvalid", rdata[i], 32'h0);
        end else begin
          e = exp_q.pop_front();
          check(cyc == e.due, "rvalid_latency", cyc, e.due);
          check(rdata[i] === e.data, "rdata", rdata[i], e.data);
        end
      end else begin
        check(rdata[i] === 32'h0, "rdata_idle", rdata[i], 32'h0);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int g0, g1, g2;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; addr[i] = 32'h0; be[i] = 4'h0; wdata[i] = 32'h0;
    end
    #1 rst_n = 1'b0;
    req[1] = 1'b1;
    #2;
    check(rvalid[0] === 1'b0, "reset_rvalid0", 32'(rvalid[0]), 32'h0);
    check(rvalid[1] === 1'b0, "reset_rvalid1", 32'(rvalid[1]), 32'h0);
    check(rdata[0] === 32'h0, "reset_rdata0", rdata[0], 32'h0);
    check(gnt[1] === 1'b1, "reset_idle_gnt", 32'(gnt[1]), 32'h1);
    req[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Preload every word so all later reads have defined contents.
    for (int i = 0; i < 2; i++) begin
      for (int w = 0; w < NWORDS; w++) issue(i, 1'b1, BASE + 32'(4 * w), 4'hF, $urandom, g0);
      idle(i, 6);
    end

    // Full write/read, read ignores be, partial-byte merge, low addr bits.
    issue(0, 1'b1, BASE + 32'h10, 4'hF, 32'hDEADBEEF, g0); idle(0, 0);
    issue(0, 1'b0, BASE + 32'h10, 4'h0, 32'h0, g0);        idle(0, 0);
    issue(0, 1'b1, BASE + 32'h20, 4'hF, 32'hAAAAAAAA, g0);
    issue(0, 1'b1, BASE + 32'h20, 4'h5, 32'h11223344, g0);
    issue(0, 1'b0, BASE + 32'h23, 4'h1, 32'h0, g0);        idle(0, 2);
    // Out-of-range reads and a dropped write; be=0 writes nothing.
    issue(0, 1'b0, BASE + 32'h200, 4'hF, 32'h0, g0);
    issue(0, 1'b0, BASE - 32'h4, 4'hF, 32'h0, g0);
    issue(0, 1'b1, BASE + 32'h200, 4'hF, 32'h55555555, g0);
    issue(0, 1'b0, BASE, 4'hF, 32'h0, g0);
    issue(0, 1'b1, BASE + 32'h30, 4'h0, 32'hFFFFFFFF, g0);
    issue(0, 1'b0, BASE + 32'h30, 4'hF, 32'h0, g0);
    idle(0, 1);
    // Request held through WAIT: next grant lands in the response cycle.
    issue(0, 1'b0, BASE + 32'h10, 4'hF, 32'h0, g0);
    issue(0, 1'b0, BASE + 32'h20, 4'hF, 32'h0, g1);
    check(g1 - g0 == LAT0, "wait_grant_gap", 32'(g1 - g0), 32'(LAT0));
    idle(0, 6);

    // LATENCY=1: write then read same word, and three streamed reads.
    issue(1, 1'b1, BASE + 32'h40, 4'hF, 32'hCAFEF00D, g0);
    issue(1, 1'b0, BASE + 32'h40, 4'hF, 32'h0, g1);
    check(g1 - g0 == 1, "b2b_wr_rd_gap", 32'(g1 - g0), 32'h1);
    issue(1, 1'b0, BASE + 32'h44, 4'hF, 32'h0, g0);
    issue(1, 1'b0, BASE + 32'h48, 4'hF, 32'h0, g1);
    issue(1, 1'b0, BASE + 32'h4C, 4'hF, 32'h0, g2);
    check(g1 - g0 == 1, "stream_gap1", 32'(g1 - g0), 32'h1);
    check(g2 - g1 == 1, "stream_gap2", 32'(g2 - g1), 32'h1);
    idle(1, 6);

    // Randomized traffic with random gaps and streaming.
    for (int i = 0; i < 2; i++) begin
      for (int n = 0; n < 150; n++) begin
        issue(i, 1'($urandom_range(0, 1)), pick_addr(), 4'($urandom_range(0, 15)), $urandom, g0);
        if ($urandom_range(0, 2) == 0) idle(i, $urandom_range(0, 3));
      end
      idle(i, 6);
    end

    // Reset two cycles after a grant: nothing may follow release.
    issue(0, 1'b0, BASE + 32'h10, 4'hF, 32'h0, g0); idle(0, 0);
    @(posedge clk); #1;
    rst_n = 1'b0; #1;
    check(rvalid[0] === 1'b0, "rst_wait_rvalid", 32'(rvalid[0]), 32'h0);
    check(rdata[0] === 32'h0, "rst_wait_rdata", rdata[0], 32'h0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(0, 8);

    // Reset during the response cycle kills rvalid/rdata at once.
    issue(0, 1'b0, BASE + 32'h20, 4'hF, 32'h0, g0); idle(0, 0);
    repeat (3) @(posedge clk);
    #1;
    check(rvalid[0] === 1'b1, "resp_before_rst", 32'(rvalid[0]), 32'h1);
    if (exp_q.size() == 1) check(rdata[0] === exp_q[0].data, "resp_data_before_rst", rdata[0], exp_q[0].data);
    else check(1'b0, "resp_queue_depth", 32'(exp_q.size()), 32'h1);
    rst_n = 1'b0; #1;
    check(rvalid[0] === 1'b0, "rst_resp_rvalid", 32'(rvalid[0]), 32'h0);
    check(rdata[0] === 32'h0, "rst_resp_rdata", rdata[0], 32'h0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(0, 8);
    // Contents survive reset.
    issue(0, 1'b0, BASE + 32'h20, 4'hF, 32'h0, g0);
    idle(0, 8);

    check(exp_q.size() == 0, "queue_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
